// File: rtl/entrada_botones.sv
// Input conditioning for the pet control unit: synchronises and debounces six raw
// inputs, emits action pulses and the tilt level, and counts timed test presses.
module entrada_botones #(
  parameter int unsigned DEBOUNCE       = 1000,
  parameter int unsigned TEST_WINDOW    = 50000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_raw,
  input  logic       awake_raw,
  input  logic       feed_raw,
  input  logic       play_raw,
  input  logic       test_raw,
  input  logic       giro_raw,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       botonPlay,
  output logic       giro,
  output logic       botonTest,
  output logic [3:0] pulseTest
);

  localparam int unsigned NCH     = 6;
  localparam int unsigned NBTN    = 5;
  localparam int unsigned CH_TEST = 4;
  localparam int unsigned CH_GIRO = 5;
  localparam int unsigned CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TW      = $clog2(TEST_WINDOW + 1);
  localparam int unsigned PW      = 4;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] WIN_LOAD = TW'(TEST_WINDOW);
  localparam logic [PW-1:0] PCNT_MAX = {PW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_EMIT     = 2'd2
  } state_e;

  logic [NCH-1:0]  raw_norm;
  logic [NCH-1:0]  sync1_q;
  logic [NCH-1:0]  sync2_q;
  logic [NCH-1:0]  stable_q;
  logic [NCH-1:0]  stable_d;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [NBTN-1:0] rise_d;
  logic [3:0]      act_q;
  logic            test_press;

  state_e          state_q;
  state_e          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [PW-1:0]   press_cnt_q;
  logic [PW-1:0]   press_cnt_d;
  logic [PW-1:0]   pulse_test_q;
  logic [PW-1:0]   pulse_test_d;
  logic            strobe_q;
  logic            strobe_d;

  // Normalise every raw input to pressed = 1
  assign raw_norm = {giro_raw, test_raw, play_raw, feed_raw, awake_raw, sleep_raw}
                    ^ {NCH{BTN_ACTIVE_LOW}};

  // A level is accepted only after DEBOUNCE consecutive disagreeing samples
  always_comb begin : debounce_comb
    for (int i = 0; i < NCH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign rise_d     = stable_d[NBTN-1:0] & ~stable_q[NBTN-1:0];
  assign test_press = rise_d[CH_TEST];

  always_ff @(posedge clk) begin : input_regs
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      act_q    <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw_norm;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      act_q    <= rise_d[3:0];
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (test_press) state_d = S_COUNTING;
      S_COUNTING: if (!test_press && (timer_q == TW'(1))) state_d = S_EMIT;
      S_EMIT:     state_d = test_press ? S_COUNTING : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A press always wins over window expiry, including the EMIT cycle
  always_comb begin : seq_outputs
    press_cnt_d  = press_cnt_q;
    timer_d      = timer_q;
    pulse_test_d = pulse_test_q;
    strobe_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (test_press) begin
          press_cnt_d = PW'(1);
          timer_d     = WIN_LOAD;
        end
      end
      S_COUNTING: begin
        if (test_press) begin
          press_cnt_d = (press_cnt_q == PCNT_MAX) ? PCNT_MAX : press_cnt_q + PW'(1);
          timer_d     = WIN_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            strobe_d     = 1'b1;
            pulse_test_d = press_cnt_q;
          end
        end
      end
      S_EMIT: begin
        if (test_press) begin
          press_cnt_d = PW'(1);
          timer_d     = WIN_LOAD;
        end else begin
          press_cnt_d = '0;
        end
      end
      default: begin
        press_cnt_d = '0;
        timer_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin : seq_regs
    if (!rst) begin
      timer_q      <= '0;
      press_cnt_q  <= '0;
      pulse_test_q <= '0;
      strobe_q     <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      press_cnt_q  <= press_cnt_d;
      pulse_test_q <= pulse_test_d;
      strobe_q     <= strobe_d;
    end
  end

  assign botonSleep = act_q[0];
  assign botonAwake = act_q[1];
  assign botonFeed  = act_q[2];
  assign botonPlay  = act_q[3];
  assign giro       = stable_q[CH_GIRO];
  assign botonTest  = strobe_q;
  assign pulseTest  = pulse_test_q;

endmodule
